iter_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider for the NPC execute stage; serves RV32M div/divu/rem/remu.
- It is the inverse of the team's combinational add/sub path: it builds division from one trial subtraction per cycle.
- Operands enter and results leave through independent valid/ready handshakes.

---
 rtl/div_pkg.sv | 15 +
 rtl/universal_adder.sv | 19 +
 rtl/iter_divider.sv | 157 +++++++++++++++
 tb/tb_iter_divider.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider slice.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN      = {1'b1, {(DIV_WIDTH-1){1'b0}}};
  localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = '1;

endpackage

// File: rtl/universal_adder.sv
// Add/subtract unit: mode=0 gives a+b, mode=1 gives a-b with carry=1 meaning no borrow.
module universal_adder #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b_eff;

  assign w_b_eff = i_b ^ {WIDTH{i_mode}};
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_mode};
  assign o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for RV32M div/divu/rem/remu, one trial subtraction per cycle.
// Optional abort input enabled by defining DIVIDER_FLUSH_EN.
module iter_divider
  import div_pkg::*;
#(
  parameter int DATAWIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef DIVIDER_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DATAWIDTH);
  localparam logic [DATAWIDTH-1:0] MIN_VAL  = {1'b1, {(DATAWIDTH-1){1'b0}}};
  localparam logic [DATAWIDTH-1:0] ALL_ONES = '1;

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_count;
  logic                 r_fix;
  logic [DATAWIDTH:0]   r_prem;
  logic [DATAWIDTH-1:0] r_work_q, r_dsr;
  logic                 r_neg_q, r_neg_r;
  logic [DATAWIDTH-1:0] r_quotient, r_remainder;
  logic                 r_dbz, r_ovf;

  logic                 w_flush, w_accept;
  logic                 w_dvd_neg, w_dsr_neg, w_is_zero, w_is_ovf;
  logic [DATAWIDTH:0]   w_shift_rem, w_trial;
  logic                 w_no_borrow, w_add_ovf_unused, w_prem_msb_unused;

`ifdef DIVIDER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_accept  = in_valid && in_ready && !w_flush;
  assign w_dvd_neg = is_signed && dividend[DATAWIDTH-1];
  assign w_dsr_neg = is_signed && divisor[DATAWIDTH-1];
  assign w_is_zero = (divisor == '0);
  assign w_is_ovf  = is_signed && (dividend == MIN_VAL) && (divisor == ALL_ONES);

  // The top partial-remainder bit is always 0 between iterations; only the shift drops it.
  assign w_shift_rem       = {r_prem[DATAWIDTH-1:0], r_work_q[DATAWIDTH-1]};
  assign w_prem_msb_unused = r_prem[DATAWIDTH];

  universal_adder #(.WIDTH(DATAWIDTH + 1)) u_trial_sub (
    .i_a        (w_shift_rem),
    .i_b        ({1'b0, r_dsr}),
    .i_mode     (1'b1),
    .o_sum      (w_trial),
    .o_carry    (w_no_borrow),
    .o_overflow (w_add_ovf_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next = (w_is_zero || w_is_ovf) ? DONE : CALC;
      end
      CALC: if (r_fix) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_flush) w_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || w_flush) begin
      r_count     <= '0;
      r_fix       <= 1'b0;
      r_prem      <= '0;
      r_work_q    <= '0;
      r_dsr       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_dbz <= 1'b0;
          r_ovf <= 1'b0;
          if (w_is_zero) begin
            r_quotient  <= ALL_ONES;
            r_remainder <= dividend;
            r_dbz       <= 1'b1;
          end else if (w_is_ovf) begin
            r_quotient  <= MIN_VAL;
            r_remainder <= '0;
            r_ovf       <= 1'b1;
          end else begin
            r_work_q <= w_dvd_neg ? -dividend : dividend;
            r_dsr    <= w_dsr_neg ? -divisor : divisor;
            r_prem   <= '0;
            r_count  <= '0;
            r_fix    <= 1'b0;
            r_neg_q  <= w_dvd_neg ^ w_dsr_neg;
            r_neg_r  <= w_dvd_neg;
          end
        end
        CALC: begin
          if (r_fix) begin
            r_quotient  <= r_neg_q ? -r_work_q : r_work_q;
            r_remainder <= r_neg_r ? -r_prem[DATAWIDTH-1:0] : r_prem[DATAWIDTH-1:0];
            r_fix       <= 1'b0;
          end else begin
            r_work_q <= {r_work_q[DATAWIDTH-2:0], w_no_borrow};
            r_prem   <= w_no_borrow ? w_trial : w_shift_rem;
            r_count  <= r_count + CNT_W'(1);
            if (r_count == CNT_W'(DATAWIDTH - 1)) r_fix <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          r_dbz <= 1'b0;
          r_ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: arithmetic reference model, scoreboard compare process, literal pins.
module tb_iter_divider;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [DW-1:0] divisor = '0;
  logic          is_signed = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  iter_divider #(.DATAWIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef DIVIDER_FLUSH_EN
    .flush       (flush),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // RV32M semantics from plain integer arithmetic (SV division truncates toward zero).
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
    exp_t   e;
    longint sa, sb;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.dbz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a;
      e.r = '0;
      e.ovf = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.q = DW'(sa / sb);
      e.r = DW'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Scoreboard: every cycle the result is presented it must equal the model's oldest entry.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        check("sb_quotient", quotient, exp_q[0].q);
        check("sb_remainder", remainder, exp_q[0].r);
        check("sb_div_by_zero", 32'(div_by_zero), 32'(exp_q[0].dbz));
        check("sb_overflow", 32'(overflow), 32'(exp_q[0].ovf));
        check("sb_in_ready_low", 32'(in_ready), 32'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic recover();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Accept one operation, measure latency, optionally stall the consumer, then retire it.
  task automatic do_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic s, input int exp_lat, input logic [DW-1:0] ql,
                       input logic [DW-1:0] rl, input logic dl, input logic ol, input int hold);
    int lat = 0;
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (lat == 0) begin
      recover();
      return;
    end
    check({tag, "_q_lit"}, quotient, ql);
    check({tag, "_r_lit"}, remainder, rl);
    check({tag, "_dbz_lit"}, 32'(div_by_zero), 32'(dl));
    check({tag, "_ovf_lit"}, 32'(overflow), 32'(ol));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_retired_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_retired_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_retired_flags"}, {30'd0, div_by_zero, overflow}, 32'd0);
  endtask

  // Start an op, then abort it at T+10 with reset (or flush) and confirm the idle state.
  task automatic abort_op(input string tag, input logic use_flush);
    dividend  = 32'd1000;
    divisor   = 32'd3;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check({tag, "_busy_mid_calc"}, 32'(in_ready), 32'd0);
    if (use_flush) flush = 1'b1;
    else           rst_n = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    rst_n = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_quotient"}, quotient, 32'd0);
    check({tag, "_remainder"}, remainder, 32'd0);
    check({tag, "_flags"}, {30'd0, div_by_zero, overflow}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op("u100_7",    32'd100,         32'd7,           1'b0, 33, 32'd14,        32'd2,         1'b0, 1'b0, 0);
    do_op("s_m7_2",    32'hFFFF_FFF9,   32'd2,           1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    do_op("s_7_m2",    32'd7,           32'hFFFF_FFFE,   1'b1, 33, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0, 0);
    do_op("s_m100_m7", 32'hFFFF_FF9C,   32'hFFFF_FFF9,   1'b1, 33, 32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0, 0);
    do_op("u5_0",      32'd5,           32'd0,           1'b0, 1,  32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0, 0);
    do_op("s5_0",      32'd5,           32'd0,           1'b1, 1,  32'hFFFF_FFFF, 32'd5,         1'b1, 1'b0, 0);
    do_op("s_min_m1",  32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 1,  32'h8000_0000, 32'd0,         1'b0, 1'b1, 0);
    do_op("u_min_m1",  32'h8000_0000,   32'hFFFF_FFFF,   1'b0, 33, 32'd0,         32'h8000_0000, 1'b0, 1'b0, 0);
    do_op("u_max_max", 32'hFFFF_FFFF,   32'hFFFF_FFFF,   1'b0, 33, 32'd1,         32'd0,         1'b0, 1'b0, 0);
    do_op("bp_1000",   32'd1000,        32'd10,          1'b0, 33, 32'd100,       32'd0,         1'b0, 1'b0, 10);
    do_op("b2b_max_1", 32'hFFFF_FFFF,   32'd1,           1'b0, 33, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 0);

    abort_op("rst_mid", 1'b0);
    exp_q.delete();
    do_op("after_rst", 32'd9,           32'd3,           1'b0, 33, 32'd3,         32'd0,         1'b0, 1'b0, 0);
`ifdef DIVIDER_FLUSH_EN
    abort_op("flush_mid", 1'b1);
    exp_q.delete();
    do_op("after_fl",  32'hFFFF_FFF9,   32'd2,           1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
